mux16_rr_scheduler: RTL and testbench
=====================================

Name: mux16_rr_scheduler

Overview:
- Round-robin scheduler that shares one external 16:1 single-bit mux among 16 requesters.
- Arbitrates the request lines and drives the mux select `s`.
- Captures the mux output `y` and presents it as a registered sample tagged with its source index.
- Sits in front of the existing 16:1 mux; `d[k]` is owned by requester k.

Parameters:
- N_SRC, 16, number of requesters. Fixed at 16 because the select width is 4.
- MAX_HOLD, 4, maximum consecutive samples per grant before rotation. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  scheduler enable
- req  input  16  request vector; `req[k]` high means requester k wants its bit sampled
- y  input  1  output of the external 16:1 mux (combinational from `s`)
- s  output  4  mux select, registered
- grant  output  16  one-hot grant, registered. Equals `1<<s` while serving, otherwise 0.
- valid  output  1  single-cycle pulse: `data`/`src` hold a new sample
- data  output  1  captured mux bit
- src  output  4  requester index of `data`
- busy  output  1  high while in SERVE

Behaviour:
- Reset (async, immediate): s=0, grant=0, valid=0, data=0, src=0, busy=0, state=IDLE, ptr=0, hcnt=0.
- Reset asserted mid-burst aborts the burst with no further sample.
- State machine has two states, IDLE and SERVE.
- Pick function: first set bit of `req` searching ptr, ptr+1, … ptr+15, wrapping modulo 16.
- IDLE:
  - On an edge with en=1 and |req: s<=pick, grant<=1<<pick, hcnt<=0, go to SERVE.
  - Otherwise remain in IDLE with grant=0.
- SERVE, every edge:
  - Define live = req[s] & en.
  - If live: data<=y, src<=s, valid<=1, hcnt<=hcnt+1.
  - If not live: valid<=0.
- Release occurs when !live, or when hcnt==MAX_HOLD-1 with live.
- On release:
  - ptr<=s+1 (wraps 15→0).
  - If en and |req: re-pick from the new ptr (requester s is searched last). Load s/grant with the result, hcnt<=0, stay in SERVE. There is no bubble cycle.
  - Otherwise: grant<=0 and go to IDLE.
- Latency: a request seen at edge E gives grant/s at E. The mux settles during the following cycle. `valid` rises at edge E+1. Total: 2 edges from request sampling to first data.
- A sole requester keeps being re-granted after each MAX_HOLD burst. `valid` stays continuously high.
- `valid` is low on every cycle where no sample was captured.
- busy = (state==SERVE).
- Simultaneous events:
  - en falling while serving: no sample that edge, release, go to IDLE.
  - req[s] dropping on the same edge that hcnt would expire: treat as a plain drop, with no sample.
- Requests from non-granted sources are ignored until the next pick.
- `grant` is never multi-hot.

Decomposition:
- Package mux_sched_pkg holds:
  - SEL_W=4 and N_SRC=16
  - state enum {IDLE, SERVE}
- One combinational sub-module, rr_pick16: inputs req[15:0] and ptr[3:0]; outputs idx[3:0] and found.
- rr_pick16 is instantiated once.
- The FSM, hold counter and output registers live in the top module.

Test Plan:
- Reset check: assert rst with random req/en, then deassert → s=0, grant=0, valid=0, data=0, src=0, busy=0.
- Single requester: en=1, req=16'h0004, mux driven with d=16'h0004 → first edge s=2, grant=16'h0004. From the next edge, valid=1, data=1, src=2 continuously. After every 4 samples a re-grant to 2 occurs with no gap.
- Two-way rotation: req=16'h8001, ptr=0 → 4 samples with src=0, then 4 with src=15, then src=0 again. valid never drops.
- Early drop: req=16'h0011 granted to 0, req[0] cleared after 2 samples → the next edge has valid=0 and grant becomes 16'h0010. Samples with src=4 follow.
- Enable off: while serving src=7, drop en → the next edge gives valid=0, grant=0, busy=0. req stays high but no grant is issued until en=1.
- Async reset mid-burst: assert rst between edges during a src=3 burst → all outputs 0 immediately, before the next edge. After release with req=16'h0008, arbitration restarts at ptr=0 and grants 3.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the 16-way round-robin mux scheduler.
package mux_sched_pkg;

  localparam int SEL_W = 4;
  localparam int N_SRC = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotating priority picker: first set request at ptr, ptr+1, ... ptr+15 (mod 16).
module rr_pick16
  import mux_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] k;

  // Walk from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner of an external 16:1 mux: drives the select, captures y,
// and emits tagged single-bit samples.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for en and any request
// SERVE | grant held on s; one sample per cycle while req[s] and en stay high
module mux16_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_SRC-1:0] req,
  input  logic             y,
  output logic [SEL_W-1:0] s,
  output logic [N_SRC-1:0] grant,
  output logic             valid,
  output logic             data,
  output logic [SEL_W-1:0] src,
  output logic             busy
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [3:0]       hcnt;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             live;
  logic             release_now;

  // On release the current owner goes to the back of the line, so the search
  // starts just past s; in IDLE ptr already holds that value.
  assign pick_ptr    = (state == SERVE) ? s + 4'd1 : ptr;
  assign live        = req[s] & en;
  assign release_now = !live || (hcnt == HOLD_LAST);
  assign busy        = (state == SERVE);

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      hcnt  <= '0;
      s     <= '0;
      grant <= '0;
      valid <= 1'b0;
      data  <= 1'b0;
      src   <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (en && pick_found) begin
            s     <= pick_idx;
            grant <= onehot(pick_idx);
            hcnt  <= '0;
            state <= SERVE;
          end else begin
            grant <= '0;
          end
        end
        SERVE: begin
          if (live) begin
            data  <= y;
            src   <= s;
            valid <= 1'b1;
            hcnt  <= hcnt + 4'd1;
          end else begin
            valid <= 1'b0;
          end
          // Back-to-back re-grant keeps the mux busy without a bubble cycle.
          if (release_now) begin
            ptr <= s + 4'd1;
            if (en && pick_found) begin
              s     <= pick_idx;
              grant <= onehot(pick_idx);
              hcnt  <= '0;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler with a sample scoreboard.
module tb_mux16_rr_scheduler;

  typedef struct packed {
    logic [3:0] src;
    logic       data;
  } samp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] d = '0;
  logic        y;
  logic [3:0]  s;
  logic [15:0] grant;
  logic        valid;
  logic        data;
  logic [3:0]  src;
  logic        busy;

  int    checks = 0;
  int    failures = 0;
  samp_t sb[$];
  samp_t exp_s;

  always #5 clk = ~clk;

  assign y = d[s];

  mux16_rr_scheduler #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .y     (y),
    .s     (s),
    .grant (grant),
    .valid (valid),
    .data  (data),
    .src   (src),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge, then drain one sample from the scoreboard if valid.
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        exp_s = sb.pop_front();
        chk("sample_src", 32'(src), 32'(exp_s.src));
        chk("sample_data", 32'(data), 32'(exp_s.data));
      end
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic bitv, input int n);
    samp_t e;
    e.src  = idx;
    e.data = bitv;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s"}, 32'(s), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_src"}, 32'(src), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic serve_n(input string tag, input logic [15:0] gexp, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      if (gexp != 16'h0) chk({tag, "_grant"}, 32'(grant), 32'(gexp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random stimulus present
    rst = 1'b1;
    en  = 1'($urandom_range(0, 1));
    req = 16'($urandom);
    d   = 16'($urandom);
    tick();
    tick();
    check_zero("reset_hold");
    en  = 1'b0;
    req = '0;
    rst = 1'b0;
    #1;
    check_zero("reset_release");

    // Single requester: continuous valid with re-grant after each 4-sample burst
    d   = 16'h0004;
    req = 16'h0004;
    en  = 1'b1;
    tick();
    chk("single_first_s", 32'(s), 32'd2);
    chk("single_first_grant", 32'(grant), 32'h0004);
    chk("single_first_valid", 32'(valid), 32'd0);
    chk("single_first_busy", 32'(busy), 32'd1);
    push(4'd2, 1'b1, 12);
    serve_n("single", 16'h0004, 12);
    en  = 1'b0;
    req = '0;
    tick();
    chk("single_off_valid", 32'(valid), 32'd0);
    chk("single_off_busy", 32'(busy), 32'd0);

    // Two-way rotation 0 -> 15 -> 0
    do_reset();
    d   = 16'h8000;
    req = 16'h8001;
    en  = 1'b1;
    tick();
    chk("rot_first_grant", 32'(grant), 32'h0001);
    push(4'd0, 1'b0, 4);
    push(4'd15, 1'b1, 4);
    push(4'd0, 1'b0, 4);
    serve_n("rot_a", 16'h0001, 3);
    tick();
    chk("rot_handoff_valid", 32'(valid), 32'd1);
    chk("rot_handoff_grant", 32'(grant), 32'h8000);
    chk("rot_handoff_s", 32'(s), 32'd15);
    serve_n("rot_b", 16'h8000, 3);
    tick();
    chk("rot_back_grant", 32'(grant), 32'h0001);
    serve_n("rot_c", 16'h0000, 4);
    chk("rot_drained", 32'(sb.size()), 32'd0);

    // Early drop hands over to the other requester
    do_reset();
    d   = 16'h0010;
    req = 16'h0011;
    en  = 1'b1;
    tick();
    chk("drop_first_grant", 32'(grant), 32'h0001);
    push(4'd0, 1'b0, 2);
    serve_n("drop_a", 16'h0001, 2);
    req = 16'h0010;
    tick();
    chk("drop_gap_valid", 32'(valid), 32'd0);
    chk("drop_gap_grant", 32'(grant), 32'h0010);
    chk("drop_gap_busy", 32'(busy), 32'd1);
    push(4'd4, 1'b1, 4);
    serve_n("drop_b", 16'h0000, 4);

    // Enable off while serving src 7
    do_reset();
    d   = 16'h0080;
    req = 16'h0080;
    en  = 1'b1;
    tick();
    chk("en_first_grant", 32'(grant), 32'h0080);
    push(4'd7, 1'b1, 2);
    serve_n("en_a", 16'h0080, 2);
    en = 1'b0;
    tick();
    chk("en_off_valid", 32'(valid), 32'd0);
    chk("en_off_grant", 32'(grant), 32'h0);
    chk("en_off_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_idle_grant", 32'(grant), 32'h0);
      chk("en_idle_busy", 32'(busy), 32'd0);
    end
    en = 1'b1;
    tick();
    chk("en_back_grant", 32'(grant), 32'h0080);
    chk("en_back_busy", 32'(busy), 32'd1);
    push(4'd7, 1'b1, 1);
    serve_n("en_b", 16'h0080, 1);

    // Async reset mid-burst on src 3
    do_reset();
    d   = 16'h0008;
    req = 16'h0008;
    en  = 1'b1;
    tick();
    chk("ar_first_grant", 32'(grant), 32'h0008);
    push(4'd3, 1'b1, 2);
    serve_n("ar_a", 16'h0008, 2);
    #2;
    rst = 1'b1;
    #1;
    check_zero("ar_async");
    sb.delete();
    tick();
    check_zero("ar_held");
    rst = 1'b0;
    tick();
    chk("ar_restart_s", 32'(s), 32'd3);
    chk("ar_restart_grant", 32'(grant), 32'h0008);
    chk("ar_restart_valid", 32'(valid), 32'd0);
    push(4'd3, 1'b1, 1);
    serve_n("ar_b", 16'h0008, 1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
